// File: rtl/mcpu_pkg.sv
// mcpu shared definitions: memory geometry defaults,
// arbiter state encoding and the read-return tag.
package mcpu_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_ADDR_SIZE = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/mcpu_rd_return_pipe.sv
// Delay line that carries the {valid, port} tag of each read
// grant until the RAM presents its data.
module mcpu_rd_return_pipe
  import mcpu_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t push,
  output rd_tag_t head
);

  rd_tag_t [RD_LATENCY-1:0] stg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg <= '0;
    end else begin
      stg[0] <= push;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign head = stg[RD_LATENCY-1];

endmodule

// File: rtl/mcpu_mem_arbiter.sv
// Two-port round-robin arbiter in front of the MCPU RAM, with a
// bounded ownership lock and tagged read-data return.
module mcpu_mem_arbiter
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic                 p0_lock,
  input  logic [ADDR_SIZE-1:0] p0_addr,
  input  logic [WORD_SIZE-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [WORD_SIZE-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic                 p1_lock,
  input  logic [ADDR_SIZE-1:0] p1_addr,
  input  logic [WORD_SIZE-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [WORD_SIZE-1:0] p1_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          last;
  logic          last_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic          g0;
  logic          g1;
  logic          gnt;
  logic          glock;
  logic          gwe;
  rd_tag_t       push;
  rd_tag_t       head;

  // Owner excludes the other port; otherwise the port that did
  // not win last time takes a tie.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      (state == ST_OWN0): g0 = p0_req;
      (state == ST_OWN1): g1 = p1_req;
      default: begin
        g0 = p0_req & (~p1_req | last);
        g1 = p1_req & (~p0_req | ~last);
      end
    endcase
    g0 = g0 & reset;
    g1 = g1 & reset;
  end

  assign gnt     = g0 | g1;
  assign glock   = g1 ? p1_lock : p0_lock;
  assign gwe     = g1 ? p1_we : p0_we;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    if (gnt) begin
      last_nx = g1;
      if (state == ST_IDLE) begin
        if (glock && MAX_LOCK > 1) begin
          state_nx = g1 ? ST_OWN1 : ST_OWN0;
          cnt_nx   = CW'(1);
        end
      end else if (glock && int'(cnt_inc) < MAX_LOCK) begin
        cnt_nx = cnt_inc;
      end else begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    end else if (state != ST_IDLE) begin
      // owner dropped its request: release without serving anyone
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign mem_en    = gnt;
  assign mem_we    = gnt & gwe;
  assign mem_addr  = g1 ? p1_addr : (g0 ? p0_addr : '0);
  assign mem_wdata = g1 ? p1_wdata : (g0 ? p0_wdata : '0);

  assign push.valid = gnt & ~gwe;
  assign push.port  = g1;

  mcpu_rd_return_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_ret (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .head (head)
  );

  assign p0_rvalid = head.valid & ~head.port;
  assign p1_rvalid = head.valid & head.port;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Bench for mcpu_mem_arbiter: two instances (read latency 1 and 3)
// share stimulus; a queue-based reference model predicts every cycle.
module tb_mcpu_mem_arbiter;

  localparam int MAXL = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req [2];
  logic we [2];
  logic lk [2];
  logic [7:0] addr [2];
  logic [15:0] wd [2];
  logic ga [2];
  logic gb [2];
  logic rva [2];
  logic rvb [2];
  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic ena, wea, enb, web;
  logic [7:0] ada, adb;
  logic [15:0] wda, wdb, mra, mrb;
  logic [15:0] ram [256];
  logic [15:0] qa;
  logic [15:0] qb [3];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mcpu_mem_arbiter #(.RD_LATENCY(1), .MAX_LOCK(MAXL)) u_a (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lk[0]),
    .p0_addr(addr[0]), .p0_wdata(wd[0]),
    .p0_gnt(ga[0]), .p0_rvalid(rva[0]), .p0_rdata(rda[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lk[1]),
    .p1_addr(addr[1]), .p1_wdata(wd[1]),
    .p1_gnt(ga[1]), .p1_rvalid(rva[1]), .p1_rdata(rda[1]),
    .mem_en(ena), .mem_we(wea), .mem_addr(ada),
    .mem_wdata(wda), .mem_rdata(mra)
  );

  mcpu_mem_arbiter #(.RD_LATENCY(3), .MAX_LOCK(MAXL)) u_b (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lk[0]),
    .p0_addr(addr[0]), .p0_wdata(wd[0]),
    .p0_gnt(gb[0]), .p0_rvalid(rvb[0]), .p0_rdata(rdb[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lk[1]),
    .p1_addr(addr[1]), .p1_wdata(wd[1]),
    .p1_gnt(gb[1]), .p1_rvalid(rvb[1]), .p1_rdata(rdb[1]),
    .mem_en(enb), .mem_we(web), .mem_addr(adb),
    .mem_wdata(wdb), .mem_rdata(mrb)
  );

  // RAM models: read-before-write, junk on the bus when not reading
  always @(posedge clk) begin
    qa <= (ena && !wea) ? ram[ada] : 16'($urandom);
    qb[0] <= (enb && !web) ? ram[adb] : 16'($urandom);
    qb[1] <= qb[0];
    qb[2] <= qb[1];
    if (ena && wea) ram[ada] <= wda;
  end
  assign mra = qa;
  assign mrb = qb[2];

  typedef struct {
    int due;
    int port;
    logic [15:0] data;
  } ret_t;

  ret_t rqa[$];
  ret_t rqb[$];
  logic [15:0] mref [256];
  int own = -1;
  int cnt = 0;
  int last = 1;
  int cyc = 0;
  logic e0, e1;

  task automatic eval();
    e0 = 1'b0;
    e1 = 1'b0;
    if (reset) begin
      if (own == 0) e0 = req[0];
      else if (own == 1) e1 = req[1];
      else if (req[0] && req[1]) begin
        e0 = (last == 1);
        e1 = (last == 0);
      end else begin
        e0 = req[0];
        e1 = req[1];
      end
    end
  endtask

  task automatic commit();
    int g;
    ret_t r;
    if (!reset) begin
      own = -1;
      cnt = 0;
      last = 1;
      rqa.delete();
      rqb.delete();
    end else begin
      if (rqa.size() > 0 && rqa[0].due == cyc) void'(rqa.pop_front());
      if (rqb.size() > 0 && rqb[0].due == cyc) void'(rqb.pop_front());
      if (e0 || e1) begin
        g = e1 ? 1 : 0;
        if (!we[g]) begin
          r.port = g;
          r.data = mref[addr[g]];
          r.due = cyc + 1;
          rqa.push_back(r);
          r.due = cyc + 3;
          rqb.push_back(r);
        end else begin
          mref[addr[g]] = wd[g];
        end
        last = g;
        if (own < 0) begin
          if (lk[g] && MAXL > 1) begin
            own = g;
            cnt = 1;
          end
        end else begin
          cnt++;
          if (!lk[g] || cnt >= MAXL) begin
            own = -1;
            cnt = 0;
          end
        end
      end else begin
        own = -1;
        cnt = 0;
      end
    end
    cyc++;
  endtask

  function automatic logic [61:0] exp_one(ret_t q[$]);
    logic v;
    int p;
    logic [15:0] d;
    int g;
    logic en;
    v = 1'b0;
    p = 0;
    d = '0;
    g = e1 ? 1 : 0;
    en = e0 | e1;
    if (reset && q.size() > 0 && q[0].due == cyc) begin
      v = 1'b1;
      p = q[0].port;
      d = q[0].data;
    end
    return {e0, e1, en, en & we[g],
            en ? addr[g] : 8'h0, en ? wd[g] : 16'h0,
            v && p == 0, v && p == 1,
            (v && p == 0) ? d : 16'h0, (v && p == 1) ? d : 16'h0};
  endfunction

  function automatic logic [123:0] obs();
    return {ga[0], ga[1], ena, wea, ada, wda,
            rva[0], rva[1], rda[0], rda[1],
            gb[0], gb[1], enb, web, adb, wdb,
            rvb[0], rvb[1], rdb[0], rdb[1]};
  endfunction

  function automatic logic [123:0] expv();
    return {exp_one(rqa), exp_one(rqb)};
  endfunction

  task automatic sample();
    @(negedge clk);
    eval();
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0;
      we[n] = 1'b0;
      lk[n] = 1'b0;
      addr[n] = '0;
      wd[n] = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[0] = 1'b1;
      req[1] = 1'b1;
      we[0] = 1'($urandom);
      addr[0] = 8'($urandom);
      addr[1] = 8'($urandom);
      sample();
      checks++;
      if (obs() !== '0) begin
        errors++;
        $display("FAIL reset got=%h exp=0", obs());
      end
      advance();
    end
    idle();
    reset = 1'b1;
  endtask

  task automatic test_preload();
    int i = 0;
    for (int k = 0; k < 300 && i < 256; k++) begin
      req[1] = 1'b1;
      we[1] = 1'b1;
      addr[1] = 8'(i);
      if (k == 0 || e1) wd[1] = 16'($urandom);
      sample();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL preload cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (e1) i++;
      advance();
    end
    idle();
  endtask

  task automatic test_p1_alone();
    for (int s = 0; s < 6; s++) begin
      idle();
      if (s < 2) begin
        req[1] = 1'b1;
        we[1] = (s == 0);
        addr[1] = 8'd3;
        wd[1] = (s == 0) ? 16'h2064 : 16'h0;
      end
      sample();
      if (s < 2) begin
        checks++;
        if (ga[1] !== 1'b1 || gb[1] !== 1'b1) begin
          errors++;
          $display("FAIL p1_gnt s=%0d got=%b%b exp=11", s, ga[1], gb[1]);
        end
      end
      checks++;
      if ({ga[0], gb[0], rva[0], rvb[0], rda[0], rdb[0]} !== '0) begin
        errors++;
        $display("FAIL p0_quiet s=%0d got=%b%b%b%b exp=0", s, ga[0], gb[0], rva[0], rvb[0]);
      end
      checks++;
      if (rva[1] !== (s == 2) || (s == 2 && rda[1] !== 16'h2064)) begin
        errors++;
        $display("FAIL p1_rvalid s=%0d got=%b/%h exp=%b/2064", s, rva[1], rda[1], s == 2);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL p1_alone cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_alternate();
    int k0 = 0;
    int k1 = 0;
    int want = 0;
    for (int k = 0; k < 14; k++) begin
      req[0] = (k < 10);
      req[1] = (k < 10);
      we[0] = 1'b0;
      we[1] = 1'b0;
      addr[0] = 8'(40 + k0);
      addr[1] = 8'(80 + k1);
      sample();
      if (k < 10) begin
        checks++;
        if (ga[want] !== 1'b1 || ga[1-want] !== 1'b0) begin
          errors++;
          $display("FAIL alternate k=%0d got=%b%b exp_port=%0d", k, ga[0], ga[1], want);
        end
        want = 1 - want;
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL alt_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (e0) k0++;
      if (e1) k1++;
      advance();
    end
    idle();
  endtask

  task automatic test_lock_max();
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 24; k++) begin
      req[1] = (n1 < 12);
      we[1] = 1'b1;
      lk[1] = (n1 < 12);
      addr[1] = 8'(200 + n1);
      wd[1] = 16'(16'h5000 + n1);
      req[0] = (k >= 1 && n0 < 3);
      we[0] = 1'b0;
      lk[0] = 1'b0;
      addr[0] = 8'(50 + n0);
      sample();
      if (k <= 8) begin
        checks++;
        if (ga[1] !== (k < 8) || ga[0] !== (k == 8)) begin
          errors++;
          $display("FAIL lock_max k=%0d got=%b%b exp=%b%b", k, ga[0], ga[1], k == 8, k < 8);
        end
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL lock_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (e0) n0++;
      if (e1) n1++;
      advance();
    end
    idle();
  endtask

  task automatic test_lock_release();
    logic [1:0] g;
    for (int s = 0; s < 7; s++) begin
      idle();
      unique case (s)
        0: begin req[0] = 1'b1; lk[0] = 1'b1; addr[0] = 8'd60; g = 2'b10; end
        1: begin
          req[0] = 1'b1; lk[0] = 1'b1; addr[0] = 8'd61;
          req[1] = 1'b1; addr[1] = 8'd70; g = 2'b10;
        end
        2: begin req[1] = 1'b1; addr[1] = 8'd70; g = 2'b00; end
        3: begin req[1] = 1'b1; addr[1] = 8'd70; g = 2'b01; end
        default: g = 2'b00;
      endcase
      sample();
      checks++;
      if ({ga[0], ga[1]} !== g || ena !== (g != 2'b00)) begin
        errors++;
        $display("FAIL lock_release s=%0d got=%b%b en=%b exp=%b", s, ga[0], ga[1], ena, g);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL release_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_latency3();
    int rel;
    logic [15:0] d;
    for (int s = 0; s < 10; s++) begin
      idle();
      if (s < 2) begin
        req[1] = 1'b1;
        we[1] = 1'b1;
        addr[1] = 8'(100 + s);
        wd[1] = (s == 0) ? 16'h0011 : 16'h0068;
      end else if (s < 4) begin
        req[0] = 1'b1;
        addr[0] = 8'(100 + s - 2);
      end
      sample();
      rel = s - 2;
      if (rel >= 0) begin
        d = (rel == 3) ? 16'h0011 : (rel == 4) ? 16'h0068 : 16'h0;
        checks++;
        if (rvb[0] !== (rel == 3 || rel == 4) || rdb[0] !== d) begin
          errors++;
          $display("FAIL lat3 rel=%0d got=%b/%h exp=%b/%h", rel, rvb[0], rdb[0], rel == 3 || rel == 4, d);
        end
        d = (rel == 1) ? 16'h0011 : (rel == 2) ? 16'h0068 : 16'h0;
        checks++;
        if (rva[0] !== (rel == 1 || rel == 2) || rda[0] !== d) begin
          errors++;
          $display("FAIL lat1 rel=%0d got=%b/%h exp=%b/%h", rel, rva[0], rda[0], rel == 1 || rel == 2, d);
        end
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL lat_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    req[0] = 1'b1;
    addr[0] = 8'd100;
    sample();
    checks++;
    if (ga[0] !== 1'b1 || gb[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt got=%b%b exp=11", ga[0], gb[0]);
    end
    advance();
    idle();
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL mid_reset_out got=%h exp=0", obs());
    end
    for (int k = 0; k < 2; k++) begin
      sample();
      advance();
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        req[0] = 1'b1;
        req[1] = 1'b1;
        addr[0] = 8'd101;
        addr[1] = 8'd3;
      end else begin
        idle();
      end
      sample();
      if (k < 4) begin
        checks++;
        if ({rva[0], rva[1], rvb[0], rvb[1]} !== 4'b0) begin
          errors++;
          $display("FAIL stale_rvalid k=%0d got=%b%b%b%b exp=0000", k, rva[0], rva[1], rvb[0], rvb[1]);
        end
      end
      if (k == 4) begin
        checks++;
        if (ga[0] !== 1'b1 || ga[1] !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_tie got=%b%b exp=10", ga[0], ga[1]);
        end
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      advance();
    end
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3004; k++) begin
      if (k >= 3000) idle();
      sample();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      advance();
      if (k < 3000) begin
        for (int n = 0; n < 2; n++) begin
          if (!req[n] || (n == 0 ? e0 : e1)) begin
            req[n] = ($urandom_range(3) != 0);
            we[n] = 1'($urandom_range(1));
            lk[n] = ($urandom_range(3) == 0);
            addr[n] = 8'($urandom);
            wd[n] = 16'($urandom);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_preload();
    test_p1_alone();
    test_alternate();
    test_lock_max();
    test_lock_release();
    test_latency3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
